// File: rtl/writeback_if.sv
// Writeback stage port bundle: upstream retire handshake plus the register-file write port and counters.
`timescale 1ns/1ps
interface writeback_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
);
   logic             valid_i;
   logic             ready_o;
   logic [XLEN-1:0]  y_in;
   logic [XLEN-1:0]  pc_i;
   logic [4:0]       itype_i;
   logic [31:0]      ir_i;
   logic [XLEN-1:0]  mem_i;
   logic             rd_we_o;
   logic [4:0]       rd_addr_o;
   logic [XLEN-1:0]  rd_data_o;
   logic             misalign_o;
   logic [CNT_W-1:0] retired_o;

   modport slave (
      input  valid_i, y_in, pc_i, itype_i, ir_i, mem_i,
      output ready_o, rd_we_o, rd_addr_o, rd_data_o, misalign_o, retired_o
   );

   modport master (
      output valid_i, y_in, pc_i, itype_i, ir_i, mem_i,
      input  ready_o, rd_we_o, rd_addr_o, rd_data_o, misalign_o, retired_o
   );
endinterface

// File: rtl/writeback.sv
// Final pipeline stage: load extraction, result select, register-file write and retire count.
// Optional MISALIGN_TRAP_EN: misaligned LH/LHU/LW commit as a trap pulse instead of a write.
`timescale 1ns/1ps
`ifndef RTYPE
`define RTYPE 5'd0
`endif
`ifndef ITYPE
`define ITYPE 5'd1
`endif
`ifndef LTYPE
`define LTYPE 5'd2
`endif
`ifndef STYPE
`define STYPE 5'd3
`endif
`ifndef BTYPE
`define BTYPE 5'd4
`endif
`ifndef JTYPE
`define JTYPE 5'd5
`endif

module writeback #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input logic       clk,
   input logic       reset,
   writeback_if.slave wb
);
   typedef enum logic {IDLE, LOAD_WAIT} state_t;

   typedef struct packed {
      logic [4:0] rd;
      logic [2:0] funct3;
      logic [1:0] off;
   } ld_req_t;

   state_t           state, state_nxt;
   ld_req_t          ld_q;
   logic             accept, is_load, wr_ok;
   logic [4:0]       rd;
   logic [2:0]       funct3;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [XLEN-1:0]  ld_data;
   logic             ld_ok, ld_mis;

   assign rd      = wb.ir_i[11:7];
   assign funct3  = wb.ir_i[14:12];
   assign is_load = (wb.itype_i == `LTYPE);
   assign wr_ok   = (rd != 5'd0) && (wb.itype_i != `STYPE) && (wb.itype_i != `BTYPE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      wb.ready_o = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            wb.ready_o = 1'b1;
            accept     = wb.valid_i;
            if (wb.valid_i && is_load) state_nxt = LOAD_WAIT;
         end
         LOAD_WAIT: state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Load word arrives one cycle after accept, so extraction works off the latched request.
   always_comb begin
      ld_byte = wb.mem_i[8*ld_q.off +: 8];
      ld_half = ld_q.off[1] ? wb.mem_i[31:16] : wb.mem_i[15:0];
      ld_data = '0;
      ld_ok   = 1'b1;
      case (ld_q.funct3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'h0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'h0, ld_half};
         3'b010:  ld_data = wb.mem_i;
         default: ld_ok   = 1'b0;
      endcase
`ifdef MISALIGN_TRAP_EN
      ld_mis = (((ld_q.funct3 == 3'b001) || (ld_q.funct3 == 3'b101)) && ld_q.off[0]) ||
               ((ld_q.funct3 == 3'b010) && (ld_q.off != 2'd0));
`else
      ld_mis = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ld_q          <= '0;
         wb.rd_we_o    <= 1'b0;
         wb.rd_addr_o  <= '0;
         wb.rd_data_o  <= '0;
         wb.misalign_o <= 1'b0;
         wb.retired_o  <= '0;
      end else begin
         wb.rd_we_o    <= 1'b0;
         wb.misalign_o <= 1'b0;
         if (state == LOAD_WAIT) begin
            if (ld_mis) begin
               // Trapped loads leave the write port and retire count untouched.
               wb.misalign_o <= 1'b1;
            end else begin
               wb.rd_addr_o <= ld_q.rd;
               wb.rd_data_o <= ld_data;
               wb.rd_we_o   <= ld_ok && (ld_q.rd != 5'd0);
               wb.retired_o <= wb.retired_o + CNT_W'(1);
            end
         end else if (accept) begin
            if (is_load) begin
               ld_q <= '{rd: rd, funct3: funct3, off: wb.y_in[1:0]};
            end else begin
               wb.rd_addr_o <= rd;
               wb.rd_data_o <= (wb.itype_i == `JTYPE) ? wb.pc_i + XLEN'(4) : wb.y_in;
               wb.rd_we_o   <= wr_ok;
               wb.retired_o <= wb.retired_o + CNT_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_writeback.sv
// Bench for writeback: expected commits are queued on accept and checked as the DUT retires them.
`timescale 1ns/1ps
`ifndef RTYPE
`define RTYPE 5'd0
`endif
`ifndef ITYPE
`define ITYPE 5'd1
`endif
`ifndef LTYPE
`define LTYPE 5'd2
`endif
`ifndef STYPE
`define STYPE 5'd3
`endif
`ifndef BTYPE
`define BTYPE 5'd4
`endif
`ifndef JTYPE
`define JTYPE 5'd5
`endif

module tb_writeback;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   writeback_if #(.XLEN(32), .CNT_W(64)) bus ();
   writeback #(.XLEN(32), .CNT_W(64)) dut (.clk(clk), .reset(reset), .wb(bus));

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        mis;
      logic        cnt;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   logic [63:0] model_cnt = '0;
   logic [63:0] last_ret = '0;
   exp_t        me;

   function automatic exp_t model(input logic [4:0] it, input logic [4:0] rd, input logic [2:0] f3,
                                  input logic [31:0] y, input logic [31:0] pc, input logic [31:0] mem);
      exp_t e;
      logic [7:0]  b;
      logic [15:0] h;
      e.addr = rd; e.mis = 1'b0; e.cnt = 1'b1;
      e.we   = (rd != 5'd0) && (it != `STYPE) && (it != `BTYPE);
      e.data = y;
      if (it == `JTYPE) e.data = pc + 32'd4;
      if (it == `LTYPE) begin
         case (y[1:0])
            2'd0: b = mem[7:0];
            2'd1: b = mem[15:8];
            2'd2: b = mem[23:16];
            default: b = mem[31:24];
         endcase
         h = y[1] ? mem[31:16] : mem[15:0];
         case (f3)
            3'd0: e.data = {{24{b[7]}}, b};
            3'd4: e.data = {24'h0, b};
            3'd1: e.data = {{16{h[15]}}, h};
            3'd5: e.data = {16'h0, h};
            3'd2: e.data = mem;
            default: begin e.we = 1'b0; e.data = 32'h0; end
         endcase
`ifdef MISALIGN_TRAP_EN
         if (((f3 == 3'd1 || f3 == 3'd5) && y[0]) || (f3 == 3'd2 && y[1:0] != 2'd0)) begin
            e.we = 1'b0; e.mis = 1'b1; e.cnt = 1'b0;
         end
`endif
      end
      return e;
   endfunction

   // Scoreboard: any visible commit (counter step, write strobe or trap) consumes one expected entry.
   always @(negedge clk) begin
      if (reset && (bus.retired_o !== last_ret || bus.rd_we_o || bus.misalign_o)) begin
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_unexpected we=%0b mis=%0b retired=%0d", bus.rd_we_o, bus.misalign_o, bus.retired_o);
         end else begin
            me = sb.pop_front();
            if (me.cnt) model_cnt = model_cnt + 64'd1;
            checks++;
            if (bus.rd_we_o !== me.we) begin
               failures++; $display("FAIL sb_we got=%0b exp=%0b", bus.rd_we_o, me.we);
            end
            if (me.we) begin
               checks++;
               if (bus.rd_addr_o !== me.addr) begin
                  failures++; $display("FAIL sb_addr got=%0d exp=%0d", bus.rd_addr_o, me.addr);
               end
               checks++;
               if (bus.rd_data_o !== me.data) begin
                  failures++; $display("FAIL sb_data got=%h exp=%h", bus.rd_data_o, me.data);
               end
            end
            checks++;
            if (bus.misalign_o !== me.mis) begin
               failures++; $display("FAIL sb_misalign got=%0b exp=%0b", bus.misalign_o, me.mis);
            end
            checks++;
            if (bus.retired_o !== model_cnt) begin
               failures++; $display("FAIL sb_retired got=%0d exp=%0d", bus.retired_o, model_cnt);
            end
         end
         last_ret = bus.retired_o;
      end
   end

   task automatic drive(input logic [4:0] it, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [31:0] y, input logic [31:0] pc);
      bus.valid_i = 1'b1; bus.itype_i = it; bus.ir_i = {17'h0, f3, rd, 7'h13};
      bus.y_in = y; bus.pc_i = pc;
   endtask

   // Presents one instruction, waits for acceptance, queues its expected commit; loads get mem_i next cycle.
   task automatic issue(input logic [4:0] it, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [31:0] y, input logic [31:0] pc, input logic [31:0] mem);
      int n = 0;
      @(negedge clk);
      drive(it, rd, f3, y, pc);
      while (!bus.ready_o && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (bus.ready_o !== 1'b1) begin
         failures++; $display("FAIL ready_timeout got=%0b exp=1", bus.ready_o);
      end
      @(posedge clk); #1;
      sb.push_back(model(it, rd, f3, y, pc, mem));
      bus.valid_i = 1'b0;
      if (it == `LTYPE) begin
         @(negedge clk);
         bus.mem_i = mem;
      end
   endtask

   task automatic drain(input string name);
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++; $display("FAIL %s_drain pending=%0d exp=0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset;
      bus.valid_i = 1'b0; bus.itype_i = '0; bus.ir_i = '0; bus.y_in = '0; bus.pc_i = '0; bus.mem_i = '0;
      #3;
      checks++;
      if ({bus.ready_o, bus.rd_we_o, bus.misalign_o} !== 3'b100) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=100", {bus.ready_o, bus.rd_we_o, bus.misalign_o});
      end
      checks++;
      if (bus.rd_addr_o !== 5'd0 || bus.rd_data_o !== 32'd0 || bus.retired_o !== 64'd0) begin
         failures++; $display("FAIL reset_data got=%0d/%h/%0d exp=0/0/0", bus.rd_addr_o, bus.rd_data_o, bus.retired_o);
      end
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_alu;
      issue(`ITYPE, 5'd5, 3'd0, 32'h0000_1234, 32'h0, 32'h0);
      @(negedge clk);
      checks++;
      if (bus.retired_o !== 64'd1 || bus.rd_data_o !== 32'h1234) begin
         failures++; $display("FAIL alu_addi got=%0d/%h exp=1/00001234", bus.retired_o, bus.rd_data_o);
      end
      issue(`RTYPE, 5'd31, 3'd0, 32'hA5A5_5A5A, 32'h0, 32'h0);
      drain("alu");
   endtask

   task automatic test_loads;
      issue(`LTYPE, 5'd3, 3'b000, 32'h0000_0102, 32'h0, 32'h0080_0000);
      checks++;
      if (bus.ready_o !== 1'b0) begin
         failures++; $display("FAIL load_wait_ready got=%0b exp=0", bus.ready_o);
      end
      issue(`LTYPE, 5'd4, 3'b101, 32'h0000_0002, 32'h0, 32'hBEEF_0000);
      issue(`LTYPE, 5'd6, 3'b010, 32'h0000_0000, 32'h0, 32'hDEAD_BEEF);
      issue(`LTYPE, 5'd7, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_F100);
      issue(`LTYPE, 5'd8, 3'b001, 32'h0000_0000, 32'h0, 32'h1234_8001);
      issue(`LTYPE, 5'd9, 3'b000, 32'h0000_0003, 32'h0, 32'h7F00_0000);
      issue(`LTYPE, 5'd10, 3'b011, 32'h0000_0000, 32'h0, 32'h5555_5555);
      issue(`LTYPE, 5'd0, 3'b010, 32'h0000_0000, 32'h0, 32'h1111_2222);
      drain("loads");
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      drive(`RTYPE, 5'd4, 3'd0, 32'h11, 32'h0);
      @(posedge clk); #1;
      sb.push_back(model(`RTYPE, 5'd4, 3'd0, 32'h11, 32'h0, 32'h0));
      drive(`LTYPE, 5'd6, 3'b010, 32'h200, 32'h0);
      @(negedge clk);
      checks++;
      if ({bus.ready_o, bus.rd_we_o} !== 2'b11) begin
         failures++; $display("FAIL b2b_c1 got=%b exp=11", {bus.ready_o, bus.rd_we_o});
      end
      @(posedge clk); #1;
      sb.push_back(model(`LTYPE, 5'd6, 3'b010, 32'h200, 32'h0, 32'hCAFE_F00D));
      bus.mem_i = 32'hCAFE_F00D;
      drive(`RTYPE, 5'd8, 3'd0, 32'h22, 32'h0);
      @(negedge clk);
      checks++;
      if ({bus.ready_o, bus.rd_we_o} !== 2'b00) begin
         failures++; $display("FAIL b2b_c2 got=%b exp=00", {bus.ready_o, bus.rd_we_o});
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({bus.ready_o, bus.rd_we_o} !== 2'b11) begin
         failures++; $display("FAIL b2b_c3 got=%b exp=11", {bus.ready_o, bus.rd_we_o});
      end
      @(posedge clk); #1;
      sb.push_back(model(`RTYPE, 5'd8, 3'd0, 32'h22, 32'h0, 32'h0));
      bus.valid_i = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.rd_we_o !== 1'b1) begin
         failures++; $display("FAIL b2b_c4 got=%0b exp=1", bus.rd_we_o);
      end
      drain("b2b");
   endtask

   task automatic test_suppress_link;
      issue(`ITYPE, 5'd0, 3'd0, 32'h0000_0077, 32'h0, 32'h0);
      issue(`STYPE, 5'd7, 3'd2, 32'h0000_0100, 32'h0, 32'h0);
      issue(`BTYPE, 5'd9, 3'd0, 32'h0000_0001, 32'h0, 32'h0);
      issue(`JTYPE, 5'd1, 3'd0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0);
      issue(`JTYPE, 5'd2, 3'd0, 32'h0000_0040, 32'h0000_0100, 32'h0);
      drain("suppress");
   endtask

   task automatic test_idle;
      logic [63:0] r;
      r = bus.retired_o;
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (bus.rd_we_o !== 1'b0 || bus.retired_o !== r) begin
            failures++; $display("FAIL idle got=%0b/%0d exp=0/%0d", bus.rd_we_o, bus.retired_o, r);
         end
      end
   endtask

`ifdef MISALIGN_TRAP_EN
   task automatic test_misalign;
      issue(`LTYPE, 5'd12, 3'b001, 32'h0000_0001, 32'h0, 32'hAAAA_BBBB);
      issue(`LTYPE, 5'd13, 3'b010, 32'h0000_0002, 32'h0, 32'hCCCC_DDDD);
      issue(`LTYPE, 5'd14, 3'b101, 32'h0000_0002, 32'h0, 32'h9876_0000);
      drain("misalign");
   endtask
`endif

   task automatic test_reset_midload;
      issue(`LTYPE, 5'd11, 3'b010, 32'h0, 32'h0, 32'h1357_9BDF);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({bus.ready_o, bus.rd_we_o, bus.misalign_o} !== 3'b100 || bus.retired_o !== 64'd0 ||
          bus.rd_addr_o !== 5'd0 || bus.rd_data_o !== 32'd0) begin
         failures++; $display("FAIL midload_reset got=%b/%0d/%0d/%h exp=100/0/0/0",
                              {bus.ready_o, bus.rd_we_o, bus.misalign_o}, bus.retired_o, bus.rd_addr_o, bus.rd_data_o);
      end
      sb.delete();
      model_cnt = '0;
      last_ret = '0;
      @(negedge clk); reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (bus.rd_we_o !== 1'b0 || bus.retired_o !== 64'd0) begin
            failures++; $display("FAIL midload_after got=%0b/%0d exp=0/0", bus.rd_we_o, bus.retired_o);
         end
      end
      issue(`ITYPE, 5'd2, 3'd0, 32'h0000_00AB, 32'h0, 32'h0);
      drain("midload");
   endtask

   initial begin
      test_reset();
      test_alu();
      test_loads();
      test_back_to_back();
      test_suppress_link();
      test_idle();
`ifdef MISALIGN_TRAP_EN
      test_misalign();
`endif
      test_reset_midload();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
